// File: rtl/alu32_arbiter_pkg.sv
// Core-wide W-op ALU definitions shared by the arbiter and the alu32 datapath.
// Holds the funct3 encodings, the request payload layout and the sign-extend helper.
package alu32_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RES_W     = 64;
  localparam int unsigned FUNCT_W   = 4;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned ALU_TAG_W = 4;

  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SHIFTR  = 3'b101;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef struct packed {
    logic [FUNCT_W-1:0]   funct;
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [ALU_TAG_W-1:0] tag;
  } alu_req_t;

  // W-op results are always returned sign-extended from bit 31.
  function automatic logic [RES_W-1:0] sext32(input logic [XLEN-1:0] val);
    return {{(RES_W - XLEN){val[XLEN-1]}}, val};
  endfunction

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == ALU_SLL) || (funct3 == ALU_SHIFTR);
  endfunction

endpackage

// File: rtl/alu32_arbiter_alu32.sv
// Combinational 32-bit W-op ALU: ADDW/SUBW/SLLW/SRLW/SRAW, result sign-extended to 64 bits.
// Shift amounts come from b[4:0]; unknown funct3 values produce zero.
module alu32
  import alu32_arbiter_pkg::*;
(
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic [XLEN-1:0]    i_a,
  input  logic [XLEN-1:0]    i_b,
  output logic [RES_W-1:0]   o_result_c
);

  logic [XLEN-1:0]    w_res32;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt = i_b[SHAMT_W-1:0];

  always_comb begin
    w_res32 = '0;
    case (i_funct[2:0])
      ALU_ADD_SUB: w_res32 = i_funct[3] ? (i_a - i_b) : (i_a + i_b);
      ALU_SLL:     w_res32 = i_a << w_shamt;
      ALU_SHIFTR:  w_res32 = i_funct[3] ? XLEN'($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
      default:     w_res32 = '0;
    endcase
  end

  assign o_result_c = sext32(w_res32);

endmodule

// File: rtl/alu32_arbiter.sv
// Round-robin arbiter sharing one alu32 between the execute stage (port 0) and an
// auxiliary unit (port 1), with a one-entry registered response slot per requester.
module alu32_arbiter
  import alu32_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = ALU_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [FUNCT_W-1:0]  req0_funct,
  input  logic [XLEN-1:0]     req0_a,
  input  logic [XLEN-1:0]     req0_b,
  input  logic [TAG_W-1:0]    req0_tag,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [FUNCT_W-1:0]  req1_funct,
  input  logic [XLEN-1:0]     req1_a,
  input  logic [XLEN-1:0]     req1_b,
  input  logic [TAG_W-1:0]    req1_tag,

  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [RES_W-1:0]    rsp0_result,
  output logic [TAG_W-1:0]    rsp0_tag,

  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [RES_W-1:0]    rsp1_result,
  output logic [TAG_W-1:0]    rsp1_tag
);

  alu_req_t         w_req0;
  alu_req_t         w_req1;
  alu_req_t         w_sel;
  alu_req_t         r_hold;
  logic [XLEN-1:0]  w_alu_b;
  logic [RES_W-1:0] w_alu_result;

  logic  w_elig0;
  logic  w_elig1;
  logic  w_grant0;
  logic  w_grant1;
  logic  w_any_grant;
  port_e r_last_grant;

  logic             r_rsp0_valid;
  logic [RES_W-1:0] r_rsp0_result;
  logic [TAG_W-1:0] r_rsp0_tag;
  logic             r_rsp1_valid;
  logic [RES_W-1:0] r_rsp1_result;
  logic [TAG_W-1:0] r_rsp1_tag;

  always_comb begin
    w_req0       = '0;
    w_req0.funct = req0_funct;
    w_req0.a     = req0_a;
    w_req0.b     = req0_b;
    w_req0.tag   = ALU_TAG_W'(req0_tag);
    w_req1       = '0;
    w_req1.funct = req1_funct;
    w_req1.a     = req1_a;
    w_req1.b     = req1_b;
    w_req1.tag   = ALU_TAG_W'(req1_tag);
  end

  // A slot can accept when empty or being drained in the same cycle; flush blocks all grants.
  always_comb begin
    w_elig0  = 1'b0;
    w_elig1  = 1'b0;
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    w_elig0  = req0_valid & ~flush & (~r_rsp0_valid | rsp0_ready);
    w_elig1  = req1_valid & ~flush & (~r_rsp1_valid | rsp1_ready);
    w_grant0 = w_elig0 & (~w_elig1 | (r_last_grant == PORT1));
    w_grant1 = w_elig1 & (~w_elig0 | (r_last_grant == PORT0));
  end

  assign w_any_grant = w_grant0 | w_grant1;
  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;

  // Operand mux keeps presenting the last granted op when idle to avoid ALU toggling.
  always_comb begin
    w_sel   = r_hold;
    w_alu_b = '0;
    if (w_grant0) begin
      w_sel = w_req0;
    end else if (w_grant1) begin
      w_sel = w_req1;
    end
    w_alu_b = w_sel.b;
    if (is_shift(w_sel.funct[2:0])) begin
      w_alu_b = XLEN'(w_sel.b[SHAMT_W-1:0]);
    end
  end

  alu32 u_alu32 (
    .i_funct    (w_sel.funct),
    .i_a        (w_sel.a),
    .i_b        (w_alu_b),
    .o_result_c (w_alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_last_grant <= PORT1;
    end else if (w_any_grant) begin
      r_hold       <= w_sel;
      r_last_grant <= w_grant0 ? PORT0 : PORT1;
    end
  end

  // Response slot 0: flush beats load, load beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_tag    <= '0;
    end else if (flush) begin
      r_rsp0_valid  <= 1'b0;
    end else if (w_grant0) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= w_alu_result;
      r_rsp0_tag    <= TAG_W'(w_sel.tag);
    end else if (rsp0_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_tag    <= '0;
    end else if (flush) begin
      r_rsp1_valid  <= 1'b0;
    end else if (w_grant1) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= w_alu_result;
      r_rsp1_tag    <= TAG_W'(w_sel.tag);
    end else if (rsp1_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_tag    = r_rsp0_tag;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_tag    = r_rsp1_tag;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Self-checking bench for alu32_arbiter: per-port scoreboards plus a grant/slot model
// checked every cycle, and directed cases with literal expected results.
module tb_alu32_arbiter;

  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_funct = '0, req1_funct = '0;
  logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [63:0]   rsp0_result, rsp1_result;
  logic [TW-1:0] rsp0_tag, rsp1_tag;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0]   res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e_item;
  bit   m_last = 1'b1;
  bit   mv0 = 1'b0, mv1 = 1'b0;
  bit   e0, e1, g0, g1;

  alu32_arbiter #(.TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct(req0_funct),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_funct(req1_funct),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_tag(rsp1_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_alu(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] ext;
    r = '0;
    case (f[2:0])
      3'b000: r = f[3] ? (a + ~b + 32'd1) : (a + b);
      3'b001: r = a << b[4:0];
      3'b101: begin
        ext = {{32{a[31] & f[3]}}, a};
        ext = ext >> b[4:0];
        r   = ext[31:0];
      end
      default: r = '0;
    endcase
    return {{32{r[31]}}, r};
  endfunction

  // Per-cycle model: sampled mid-cycle, describes what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
      chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
      q0.delete();
      q1.delete();
      m_last = 1'b1;
      mv0 = 1'b0;
      mv1 = 1'b0;
    end else begin
      e0 = req0_valid && !flush && (!mv0 || rsp0_ready);
      e1 = req1_valid && !flush && (!mv1 || rsp1_ready);
      g0 = e0 && (!e1 || m_last);
      g1 = e1 && (!e0 || !m_last);
      chk("rsp0_valid", 64'(rsp0_valid), 64'(mv0));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(mv1));
      chk("req0_ready", 64'(req0_ready), 64'(g0));
      chk("req1_ready", 64'(req1_ready), 64'(g1));
      if (flush) begin
        if (mv0 && q0.size() > 0) void'(q0.pop_front());
        if (mv1 && q1.size() > 0) void'(q1.pop_front());
        mv0 = 1'b0;
        mv1 = 1'b0;
      end else begin
        if (mv0 && rsp0_ready) begin
          if (q0.size() == 0) chk("sb0_underflow", 64'd1, 64'd0);
          else begin
            e_item = q0.pop_front();
            chk("sb0_result", rsp0_result, e_item.res);
            chk("sb0_tag", 64'(rsp0_tag), 64'(e_item.tag));
          end
          mv0 = 1'b0;
        end
        if (mv1 && rsp1_ready) begin
          if (q1.size() == 0) chk("sb1_underflow", 64'd1, 64'd0);
          else begin
            e_item = q1.pop_front();
            chk("sb1_result", rsp1_result, e_item.res);
            chk("sb1_tag", 64'(rsp1_tag), 64'(e_item.tag));
          end
          mv1 = 1'b0;
        end
        if (g0) begin
          q0.push_back('{res: model_alu(req0_funct, req0_a, req0_b), tag: req0_tag});
          mv0 = 1'b1;
          m_last = 1'b0;
        end
        if (g1) begin
          q1.push_back('{res: model_alu(req1_funct, req1_a, req1_b), tag: req1_tag});
          mv1 = 1'b1;
          m_last = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] t);
    req0_funct = f; req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic set1(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] t);
    req1_funct = f; req1_a = a; req1_b = b; req1_tag = t;
  endtask

  // Single op on port 0 with a literal expected result, bounded wait for the grant.
  task automatic issue0(input string nm, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] t, input logic [63:0] exp);
    set0(f, a, b, t);
    req0_valid = 1'b1;
    #1;
    for (int k = 0; k < 20 && !req0_ready; k++) cyc();
    chk({nm, "_ready"}, 64'(req0_ready), 64'd1);
    cyc();
    req0_valid = 1'b0;
    chk({nm, "_valid"}, 64'(rsp0_valid), 64'd1);
    chk(nm, rsp0_result, exp);
    chk({nm, "_tag"}, 64'(rsp0_tag), 64'(t));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rsp0_result", rsp0_result, 64'd0);
    chk("reset_rsp0_tag", 64'(rsp0_tag), 64'd0);
    chk("reset_rsp1_result", rsp1_result, 64'd0);
    chk("reset_rsp1_tag", 64'(rsp1_tag), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Conflict right after reset: port 0 first, then alternate.
    set0(4'b0000, 32'd1, 32'd2, 4'h1);
    set1(4'b1000, 32'd5, 32'd7, 4'h2);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("conf_g0", 64'(req0_ready), 64'((i % 2) == 0));
      chk("conf_g1", 64'(req1_ready), 64'((i % 2) == 1));
      cyc();
      if (i % 2 == 1) begin
        chk("conf_sub", rsp1_result, 64'hFFFF_FFFF_FFFF_FFFE);
      end
    end

    // Backpressure on port 0: port 1 keeps getting every grant.
    rsp0_ready = 1'b0;
    #1;
    chk("bp_first_g0", 64'(req0_ready), 64'd1);
    cyc();
    set0(4'b0001, 32'd1, 32'h3F, 4'h9);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_g0", 64'(req0_ready), 64'd0);
      chk("bp_g1", 64'(req1_ready), 64'd1);
      chk("bp_hold", rsp0_result, 64'd3);
      cyc();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_reload_g0", 64'(req0_ready), 64'd1);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("bp_reload_valid", 64'(rsp0_valid), 64'd1);
    chk("bp_reload_sll", rsp0_result, 64'hFFFF_FFFF_8000_0000);
    chk("bp_reload_tag", 64'(rsp0_tag), 64'h9);
    cyc();

    issue0("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1, 4'h5, 64'hFFFF_FFFF_8000_0000);
    issue0("sll_31", 4'b0001, 32'd1, 32'h3F, 4'h6, 64'hFFFF_FFFF_8000_0000);
    issue0("sra_4", 4'b1101, 32'h8000_0000, 32'd4, 4'h7, 64'hFFFF_FFFF_F800_0000);
    issue0("srl_4", 4'b0101, 32'h8000_0000, 32'd4, 4'h8, 64'h0000_0000_0800_0000);
    issue0("f3_010", 4'b0010, 32'h1234_5678, 32'h9ABC_DEF0, 4'hA, 64'd0);
    issue0("sub_neg", 4'b1000, 32'd0, 32'd1, 4'hB, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();

    // Flush with both slots full and both requests pending.
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set0(4'b0000, 32'd1, 32'd1, 4'h3);
    set1(4'b0000, 32'd2, 32'd2, 4'h4);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) cyc();
    chk("pre_flush_v0", 64'(rsp0_valid), 64'd1);
    chk("pre_flush_v1", 64'(rsp1_valid), 64'd1);
    flush = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    chk("flush_g0", 64'(req0_ready), 64'd0);
    chk("flush_g1", 64'(req1_ready), 64'd0);
    cyc();
    flush = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("post_flush_v0", 64'(rsp0_valid), 64'd0);
    chk("post_flush_v1", 64'(rsp1_valid), 64'd0);
    cyc();

    // Async reset in the middle of a stream.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_v0", 64'(rsp0_valid), 64'd0);
    chk("async_v1", 64'(rsp1_valid), 64'd0);
    chk("async_r0", rsp0_result, 64'd0);
    chk("async_r1", rsp1_result, 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rerst_g0", 64'(req0_ready), 64'd1);
    chk("rerst_g1", 64'(req1_ready), 64'd0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
